motor_pwm_drv: RTL



---
 rtl/motor_pkg.sv | 13 +
 rtl/motor_chan.sv | 86 ++++++++
 rtl/motor_pwm_drv.sv | 66 ++++++
 3 files changed

// File: rtl/motor_pkg.sv
// motor_pkg: shared encodings for the motor PWM driver.
package motor_pkg;

    typedef enum logic [1:0] {CMD_STOP = 2'd0, CMD_FWD = 2'd1, CMD_REV = 2'd2} cmd_t;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RAMP = 2'd1, S_RUN = 2'd2} state_t;
    typedef enum logic {DIR_FWD = 1'b0, DIR_REV = 1'b1} dir_t;

    // Conflicting fwd/rev requests are treated as a stop, never as a direction.
    function automatic cmd_t decode(input logic en, input logic fwd, input logic rev);
        return (!en || fwd == rev) ? CMD_STOP : (fwd ? CMD_FWD : CMD_REV);
    endfunction

endpackage

// File: rtl/motor_chan.sv
// motor_chan: per-wheel FSM with soft-start duty ramp, reversal dead time and
// registered H-bridge outputs.
module motor_chan
    import motor_pkg::*;
#(
    parameter int PWM_W     = 8,
    parameter int DUTY_MAX  = 200,
    parameter int RAMP_STEP = 8,
    parameter int DEAD_CYC  = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  cmd_t             cmd,
    input  logic             estop,
    input  logic             period_end,
    input  logic [PWM_W-1:0] pwm_cnt,
    output logic             in1,
    output logic             in2,
    output logic             active
);

    localparam int DW    = $clog2(DEAD_CYC + 1);
    localparam int FIRST = (RAMP_STEP < DUTY_MAX) ? RAMP_STEP : DUTY_MAX;
    localparam logic [PWM_W-1:0] DMAX = PWM_W'(DUTY_MAX);

    state_t           state, state_n;
    dir_t             dir, dir_n, cmd_dir;
    logic [PWM_W-1:0] duty, duty_n, stepped;
    logic [PWM_W:0]   step_sum;
    logic [DW-1:0]    dead, dead_n;
    logic             quit, pwm_on;

    assign cmd_dir  = (cmd == CMD_REV) ? DIR_REV : DIR_FWD;
    assign quit     = (cmd == CMD_STOP) || (cmd_dir != dir);
    assign step_sum = {1'b0, duty} + (PWM_W+1)'(RAMP_STEP);
    assign stepped  = (step_sum >= (PWM_W+1)'(DUTY_MAX)) ? DMAX : step_sum[PWM_W-1:0];
    assign pwm_on   = pwm_cnt < duty;

    always_comb begin
        state_n = state;
        dir_n   = dir;
        duty_n  = duty;
        dead_n  = (dead != '0) ? dead - 1'b1 : dead;
        if (estop) begin
            dead_n = DW'(DEAD_CYC);
            if (state != S_IDLE) begin
                state_n = S_IDLE;
                duty_n  = '0;
            end
        end else if (state == S_IDLE) begin
            if (cmd != CMD_STOP && dead == '0) begin
                state_n = S_RAMP;
                dir_n   = cmd_dir;
                duty_n  = PWM_W'(FIRST);
            end
        end else if (quit) begin
            state_n = S_IDLE;
            duty_n  = '0;
            dead_n  = DW'(DEAD_CYC);
        end else if (state == S_RAMP && period_end) begin
            duty_n = stepped;
            if (stepped == DMAX) state_n = S_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            dir    <= DIR_FWD;
            duty   <= '0;
            dead   <= '0;
            active <= 1'b0;
            in1    <= 1'b0;
            in2    <= 1'b0;
        end else begin
            state  <= state_n;
            dir    <= dir_n;
            duty   <= duty_n;
            dead   <= dead_n;
            active <= state_n != S_IDLE;
            in1    <= (state != S_IDLE) && (dir == DIR_FWD) && pwm_on;
            in2    <= (state != S_IDLE) && (dir == DIR_REV) && pwm_on;
        end
    end

endmodule

// File: rtl/motor_pwm_drv.sv
// motor_pwm_drv: input synchronisers, shared PWM timebase and two wheel
// channels driving the H-bridge pins.
module motor_pwm_drv
    import motor_pkg::*;
#(
    parameter int PWM_W     = 8,
    parameter int PRESC     = 50,
    parameter int DUTY_MAX  = 200,
    parameter int RAMP_STEP = 8,
    parameter int DEAD_CYC  = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic estop,
    input  logic zuo1,
    input  logic zuo2,
    input  logic en1,
    input  logic you1,
    input  logic you2,
    input  logic en2,
    output logic l_in1,
    output logic l_in2,
    output logic r_in1,
    output logic r_in2,
    output logic l_active,
    output logic r_active
);

    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

    logic [6:0]       s1, s2;
    logic [PW-1:0]    presc;
    logic [PWM_W-1:0] pwm_cnt;
    logic             tick, period_end;
    cmd_t             cmd_l, cmd_r;

    assign tick       = presc == PW'(PRESC - 1);
    assign period_end = tick && (&pwm_cnt);
    assign cmd_l      = decode(s2[2], s2[0], s2[1]);
    assign cmd_r      = decode(s2[5], s2[3], s2[4]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= '0;
            s2      <= '0;
            presc   <= '0;
            pwm_cnt <= '0;
        end else begin
            s1      <= {estop, en2, you2, you1, en1, zuo2, zuo1};
            s2      <= s1;
            presc   <= tick ? '0 : presc + 1'b1;
            if (tick) pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    motor_chan #(.PWM_W(PWM_W), .DUTY_MAX(DUTY_MAX), .RAMP_STEP(RAMP_STEP), .DEAD_CYC(DEAD_CYC)) u_left (
        .clk(clk), .rst_n(rst_n), .cmd(cmd_l), .estop(s2[6]), .period_end(period_end),
        .pwm_cnt(pwm_cnt), .in1(l_in1), .in2(l_in2), .active(l_active)
    );

    motor_chan #(.PWM_W(PWM_W), .DUTY_MAX(DUTY_MAX), .RAMP_STEP(RAMP_STEP), .DEAD_CYC(DEAD_CYC)) u_right (
        .clk(clk), .rst_n(rst_n), .cmd(cmd_r), .estop(s2[6]), .period_end(period_end),
        .pwm_cnt(pwm_cnt), .in1(r_in1), .in2(r_in2), .active(r_active)
    );

endmodule
